multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control state machine for the multi-cycle MIPS datapath. Sequences instruction fetch, decode, execute, memory and write-back over several cycles, sharing one ALU for PC+4, branch-target and execute arithmetic. Drives the 3-bit ALUOp that the ALU controller decodes, together with all datapath mux, write-enable and memory strobes. Memory accesses stall on a ready handshake.

## Interface
- (none): no parameters; the jump feature is selected by macro.
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- op_i  in  6  opcode, IR[31:26]; IR is stable from DECODE until the next fetch completes
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if branch condition holds (datapath gates with zero)
- branch_ne_o  out  1  invert zero for bne
- i_or_d_o  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- ir_write_o  out  1  IR load
- mem_to_reg_o  out  1  write-back data: 0 = ALUOut, 1 = MDR
- reg_dst_o  out  1  destination: 0 = rt, 1 = rd
- reg_write_o  out  1  register-file write
- alu_src_a_o  out  1  ALU A: 0 = PC, 1 = reg A
- alu_src_b_o  out  2  ALU B: 00 = reg B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2
- alu_op_o  out  3  000 = R-type (funct), 001 = add, 010 = sltiu, 011 = sub/beq, 100 = lui, 101 = or, 111 = bne
- pc_source_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- imm_zext_o  out  1  zero-extend imm (ori), otherwise sign-extend
- state_o  out  4  current state, for debug
- illegal_o  out  1  one-cycle pulse on an unknown opcode

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, WB_LOAD 4, MEM_WRITE 5, EXEC_R 6, WB_R 7, BRANCH 8, EXEC_I 9, WB_I 10, JUMP 11. Codes 12–15 are unused and return to FETCH.
- Outputs are decoded from the state and mem_ready_i. Any signal not listed for a state is 0.
- FETCH: mem_read, src_a = 0, src_b = 01, alu_op = 001. ir_write and pc_write are asserted only when mem_ready_i = 1; advance to DECODE on ready, otherwise hold.
- DECODE: src_a = 0, src_b = 11, alu_op = 001 (branch target into ALUOut). Next state by opcode:
  - 0 → EXEC_R
  - 35 or 43 → MEM_ADDR
  - 4 or 5 → BRANCH
  - 8, 11, 13, 15 → EXEC_I
  - 2 → JUMP
  - any other opcode → FETCH with illegal_o = 1
- MEM_ADDR: src_a = 1, src_b = 10, alu_op = 001. Next is MEM_READ for lw (35), MEM_WRITE for sw (43).
- MEM_READ: mem_read, i_or_d = 1; hold until ready, then WB_LOAD.
- WB_LOAD: reg_write, mem_to_reg = 1, reg_dst = 0; then FETCH.
- MEM_WRITE: mem_write, i_or_d = 1; hold until ready, then FETCH.
- EXEC_R: src_a = 1, src_b = 00, alu_op = 000; then WB_R.
- WB_R: reg_write, reg_dst = 1; then FETCH.
- BRANCH: src_a = 1, src_b = 00, pc_write_cond, pc_source = 01.
  - beq: alu_op = 011.
  - bne: alu_op = 111 and branch_ne = 1.
  - Then FETCH.
- EXEC_I: src_a = 1, src_b = 10, imm_zext = (op == 13).
  - alu_op: addi 001, sltiu 010, ori 101, lui 100.
  - Then WB_I.
- WB_I: reg_write, reg_dst = 0, mem_to_reg = 0; then FETCH.
- JUMP: pc_write, pc_source = 10; then FETCH.

## Timing
- Reset: while rst_i = 1, every output is forced to 0 combinationally. On the edge sampling rst_i = 1, the state becomes FETCH, including when reset arrives mid-instruction or mid-stall.
- Latency with mem_ready_i always 1, in cycles: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3.
- Each cycle with mem_ready_i = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. During a stall, strobes stay asserted and no enable pulses.
- ir_write and pc_write in FETCH are each asserted exactly once per instruction.
- illegal_o is high only in the DECODE cycle of an unknown opcode.

## Configuration
- Macro: MC_CTRL_JUMP_EN.
- Defined: opcode 2 goes to JUMP, and the 10 encoding of pc_source_o is used.
- Undefined: the JUMP state is absent, opcode 2 is illegal (DECODE → FETCH with illegal_o), and pc_source_o never drives 10.

## Structure
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants: R 0, J 2, BEQ 4, BNE 5, ADDI 8, SLTIU 11, ORI 13, LUI 15, LW 35, SW 43
  - ALUOp codes
  - ALUSrcB and PCSource codes
- Sub-module mc_ctrl_decode is purely combinational: state, op_i and mem_ready_i in, outputs out.
- The top level holds only the state register and next-state logic.

## Test plan
- rst_i = 1 for 2 cycles with mem_ready_i = 1 → all outputs 0. First cycle after release: state_o = 0, mem_read_o = 1, alu_src_b_o = 01, ir_write_o = 1.
- lw (op 35), ready always 1 → states 0, 1, 2, 3, 4, 0. reg_write_o = 1 with mem_to_reg_o = 1 in cycle 5.
- sw (op 43) with mem_ready_i low for 3 cycles in MEM_WRITE → mem_write_o held for 4 cycles, total 7 cycles, back to FETCH.
- bne (op 5) → BRANCH with alu_op_o = 111, branch_ne_o = 1, pc_write_cond_o = 1, pc_source_o = 01. ori (op 13) → EXEC_I with alu_op_o = 101, imm_zext_o = 1.
- Op 2 with MC_CTRL_JUMP_EN → JUMP with pc_write_o = 1, pc_source_o = 10. Op 2 without the macro, and op 63 in either build → illegal_o pulses in DECODE, then FETCH.
- rst_i asserted in EXEC_R → the next state is FETCH and no reg_write_o is issued.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and codes for the multi-cycle MIPS main controller.
// MC_CTRL_JUMP_EN enables the JUMP state and opcode 2.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_WB_LOAD   = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_WB_R      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_EXEC_I    = 4'd9,
    ST_WB_I      = 4'd10,
    ST_JUMP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SLTIU = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_BNE   = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

`ifdef MC_CTRL_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       imm_zext;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTIU,
      OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      OP_J:                         legal = JUMP_EN;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode for the multi-cycle controller: state,
// opcode and memory-ready in, datapath control word out.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // control word per state; unlisted signals stay 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_BRANCH;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.illegal   = ~op_is_legal(op_i);
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_WB_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      ST_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        if (op_i == OP_BNE) begin
          ctrl_o.alu_op    = ALU_BNE;
          ctrl_o.branch_ne = 1'b1;
        end else begin
          ctrl_o.alu_op    = ALU_SUB;
        end
      end
      ST_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.imm_zext  = (op_i == OP_ORI);
        case (op_i)
          OP_SLTIU: ctrl_o.alu_op = ALU_SLTIU;
          OP_ORI:   ctrl_o.alu_op = ALU_OR;
          OP_LUI:   ctrl_o.alu_op = ALU_LUI;
          default:  ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      ST_WB_I: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_JUMP: begin
        // unreachable unless the jump build is selected
        ctrl_o.pc_write  = JUMP_EN;
        ctrl_o.pc_source = JUMP_EN ? PCS_JUMP : PCS_ALU;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath (state register and
// next-state logic). MC_CTRL_JUMP_EN enables the JUMP state for opcode 2.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       imm_zext_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  state_e state_r;
  state_e state_next_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_gated_s;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic; memory states hold until the access completes
  always_comb begin
    state_next_s = ST_FETCH;
    case (state_r)
      ST_FETCH:     state_next_s = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op_i)
          OP_R:                                 state_next_s = ST_EXEC_R;
          OP_LW, OP_SW:                         state_next_s = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                       state_next_s = ST_BRANCH;
          OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:    state_next_s = ST_EXEC_I;
`ifdef MC_CTRL_JUMP_EN
          OP_J:                                 state_next_s = ST_JUMP;
`endif
          default:                              state_next_s = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: begin
        if (op_i == OP_LW) begin
          state_next_s = ST_MEM_READ;
        end else begin
          state_next_s = ST_MEM_WRITE;
        end
      end
      ST_MEM_READ:  state_next_s = mem_ready_i ? ST_WB_LOAD : ST_MEM_READ;
      ST_MEM_WRITE: state_next_s = mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      ST_EXEC_R:    state_next_s = ST_WB_R;
      ST_EXEC_I:    state_next_s = ST_WB_I;
      default:      state_next_s = ST_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_r),
    .op_i        (op_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl_s)
  );

  assign ctrl_gated_s    = rst_i ? '0 : ctrl_s;
  assign state_o         = rst_i ? 4'd0 : state_r;

  assign pc_write_o      = ctrl_gated_s.pc_write;
  assign pc_write_cond_o = ctrl_gated_s.pc_write_cond;
  assign branch_ne_o     = ctrl_gated_s.branch_ne;
  assign i_or_d_o        = ctrl_gated_s.i_or_d;
  assign mem_read_o      = ctrl_gated_s.mem_read;
  assign mem_write_o     = ctrl_gated_s.mem_write;
  assign ir_write_o      = ctrl_gated_s.ir_write;
  assign mem_to_reg_o    = ctrl_gated_s.mem_to_reg;
  assign reg_dst_o       = ctrl_gated_s.reg_dst;
  assign reg_write_o     = ctrl_gated_s.reg_write;
  assign alu_src_a_o     = ctrl_gated_s.alu_src_a;
  assign alu_src_b_o     = ctrl_gated_s.alu_src_b;
  assign alu_op_o        = ctrl_gated_s.alu_op;
  assign pc_source_o     = ctrl_gated_s.pc_source;
  assign imm_zext_o      = ctrl_gated_s.imm_zext;
  assign illegal_o       = ctrl_gated_s.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction stream with
// random memory stalls against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, imm_zext, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [23:0] dut_vec;

  int total = 0;
  int bad = 0;
  int ir_cnt, pcw_cnt, rw_cnt, mw_cnt, ill_cnt;

`ifdef MC_CTRL_JUMP_EN
  localparam bit JUMP_BUILD = 1'b1;
`else
  localparam bit JUMP_BUILD = 1'b0;
`endif

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
    .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
    .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .pc_source_o(pc_source), .imm_zext_o(imm_zext),
    .state_o(state), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, illegal, imm_zext, pc_source, alu_op, alu_src_b, alu_src_a,
                    reg_write, reg_dst, mem_to_reg, ir_write, mem_write, mem_read,
                    i_or_d, branch_ne, pc_write_cond, pc_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    if (o == 6'd2) return JUMP_BUILD;
    return o inside {6'd0, 6'd4, 6'd5, 6'd8, 6'd11, 6'd13, 6'd15, 6'd35, 6'd43};
  endfunction

  // Expected control word for one cycle, straight from the per-state table.
  function automatic logic [23:0] expect_outs(input int st, input logic [5:0] o, input logic rdy);
    logic pcw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw, sa, zx, ill;
    logic [1:0] sb, pcs;
    logic [2:0] aop;
    {pcw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw, sa, zx, ill} = 13'd0;
    sb = 2'd0; pcs = 2'd0; aop = 3'd0;
    case (st)
      0:  begin mr = 1'b1; sb = 2'b01; aop = 3'b001; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; aop = 3'b001; ill = !is_legal(o); end
      2:  begin sa = 1'b1; sb = 2'b10; aop = 3'b001; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin sa = 1'b1; end
      7:  begin rw = 1'b1; rdst = 1'b1; end
      8:  begin sa = 1'b1; pwc = 1'b1; pcs = 2'b01;
                aop = (o == 6'd5) ? 3'b111 : 3'b011; bne = (o == 6'd5); end
      9:  begin sa = 1'b1; sb = 2'b10; zx = (o == 6'd13);
                aop = (o == 6'd11) ? 3'b010 : (o == 6'd13) ? 3'b101 :
                      (o == 6'd15) ? 3'b100 : 3'b001; end
      10: begin rw = 1'b1; end
      11: begin pcw = 1'b1; pcs = 2'b10; end
      default: begin end
    endcase
    return {4'(st), ill, zx, pcs, aop, sb, sa, rw, rdst, m2r, irw, mw, mr, iord, bne, pwc, pcw};
  endfunction

  task automatic do_cycle(input int st, input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
    check($sformatf("op%0d_st%0d_rdy%0d", op, st, rdy), {8'd0, dut_vec},
          {8'd0, expect_outs(st, op, rdy)});
    ir_cnt  += int'(ir_write);
    pcw_cnt += int'(pc_write);
    rw_cnt  += int'(reg_write);
    mw_cnt  += int'(mem_write);
    ill_cnt += int'(illegal);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: expected path built from the opcode and stall counts.
  task automatic run_instr(input logic [5:0] o, input int fs, input int ms);
    bit is_ld, is_st, is_r, is_i, is_jmp;
    op = o;
    ir_cnt = 0; pcw_cnt = 0; rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
    is_ld  = (o == 6'd35);
    is_st  = (o == 6'd43);
    is_r   = (o == 6'd0);
    is_i   = o inside {6'd8, 6'd11, 6'd13, 6'd15};
    is_jmp = (o == 6'd2) && JUMP_BUILD;
    for (int i = 0; i < fs; i++) do_cycle(0, 1'b0);
    do_cycle(0, 1'b1);
    do_cycle(1, rnd_bit());
    if (is_ld || is_st) begin
      do_cycle(2, rnd_bit());
      for (int i = 0; i < ms; i++) do_cycle(is_ld ? 3 : 5, 1'b0);
      do_cycle(is_ld ? 3 : 5, 1'b1);
      if (is_ld) do_cycle(4, rnd_bit());
    end else if (is_r) begin
      do_cycle(6, rnd_bit());
      do_cycle(7, rnd_bit());
    end else if (is_i) begin
      do_cycle(9, rnd_bit());
      do_cycle(10, rnd_bit());
    end else if (o == 6'd4 || o == 6'd5) begin
      do_cycle(8, rnd_bit());
    end else if (is_jmp) begin
      do_cycle(11, rnd_bit());
    end
    check($sformatf("op%0d_ir_once", o), ir_cnt, 1);
    check($sformatf("op%0d_pcw_cnt", o), pcw_cnt, is_jmp ? 2 : 1);
    check($sformatf("op%0d_rw_cnt", o), rw_cnt, (is_ld || is_r || is_i) ? 1 : 0);
    check($sformatf("op%0d_mw_cnt", o), mw_cnt, is_st ? ms + 1 : 0);
    check($sformatf("op%0d_ill_cnt", o), ill_cnt, is_legal(o) ? 0 : 1);
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check(tag, {8'd0, dut_vec}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [5:0] op_pool [12] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8,
                               6'd11, 6'd13, 6'd15, 6'd2, 6'd63, 6'd1};

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    op = 6'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outs", {8'd0, dut_vec}, 32'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;

    run_instr(6'd35, 0, 0);
    run_instr(6'd43, 0, 3);
    run_instr(6'd5, 0, 0);
    run_instr(6'd13, 0, 0);
    run_instr(6'd2, 0, 0);
    run_instr(6'd63, 0, 0);
    run_instr(6'd4, 2, 0);
    run_instr(6'd35, 1, 2);

    // reset while in EXEC_R: no write-back may follow
    op = 6'd0;
    do_cycle(0, 1'b1);
    do_cycle(1, 1'b1);
    reset_cycle("reset_in_exec_r");
    run_instr(6'd15, 0, 0);

    // reset while stalled in MEM_READ
    op = 6'd35;
    do_cycle(0, 1'b1);
    do_cycle(1, 1'b1);
    do_cycle(2, 1'b1);
    do_cycle(3, 1'b0);
    reset_cycle("reset_in_mem_stall");
    run_instr(6'd11, 0, 0);

    for (int n = 0; n < 80; n++) begin
      run_instr(op_pool[$urandom_range(0, 11)], $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
